// File: rtl/keypad_concatener_if.sv
// Keypad-side handshake and entry/commit outputs of keypad_concatener.
// master = keypad scanner / consumer side, slave = the concatener itself.
interface keypad_concatener_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       key_code;
    logic             key_pressed;
    logic [WIDTH-1:0] value_out;
    logic             value_valid;
    logic [3:0]       entry_tens;
    logic [3:0]       entry_unit;
    logic [1:0]       digit_count;
    logic             error;

    modport master (
        output key_code, key_pressed,
        input  value_out, value_valid, entry_tens, entry_unit, digit_count, error
    );

    modport slave (
        input  key_code, key_pressed,
        output value_out, value_valid, entry_tens, entry_unit, digit_count, error
    );
endinterface

// File: rtl/keypad_concatener.sv
// Assembles up to two typed decimal digits into a binary value committed on Enter.
// Optional macro KEYPAD_CONCATENER_AUTOCOMMIT_EN commits as soon as the second digit lands.
module keypad_concatener #(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 15
) (
    input  logic                clock,
    input  logic                reset,
    keypad_concatener_if.slave  kp
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    localparam logic [6:0] MAX_V     = 7'(MAX_VALUE);
    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    state_t           state_reg;
    logic             key_prev_reg;
    logic [3:0]       tens_reg;
    logic [3:0]       unit_reg;
    logic [WIDTH-1:0] value_reg;
    logic             valid_reg;
    logic             error_reg;

    logic       press;
    logic       is_digit;
    logic [6:0] enter_v;
    logic [6:0] commit_v;
    logic       commit_req;

    assign press    = kp.key_pressed && !key_prev_reg;
    assign is_digit = (kp.key_code <= 4'd9);
    assign enter_v  = 7'(tens_reg) * 7'd10 + 7'(unit_reg);

`ifdef KEYPAD_CONCATENER_AUTOCOMMIT_EN
    logic [6:0] auto_v;
    assign auto_v = 7'(unit_reg) * 7'd10 + 7'(kp.key_code);
`endif

    // A commit request takes priority over the plain digit/clear handling below.
    always_comb begin
        commit_v   = enter_v;
        commit_req = press && (kp.key_code == KEY_ENTER) && (state_reg != EMPTY);
`ifdef KEYPAD_CONCATENER_AUTOCOMMIT_EN
        if (press && is_digit && (state_reg == ONE)) begin
            commit_req = 1'b1;
            commit_v   = auto_v;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= EMPTY;
            key_prev_reg <= 1'b1;   // a key held across reset release is not an event
            tens_reg     <= 4'd0;
            unit_reg     <= 4'd0;
            value_reg    <= '0;
            valid_reg    <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            key_prev_reg <= kp.key_pressed;
            valid_reg    <= 1'b0;
            if (commit_req) begin
                tens_reg  <= 4'd0;
                unit_reg  <= 4'd0;
                state_reg <= EMPTY;
                if (commit_v <= MAX_V) begin
                    value_reg <= WIDTH'(commit_v);
                    valid_reg <= 1'b1;
                    error_reg <= 1'b0;
                end else begin
                    error_reg <= 1'b1;
                end
            end else if (press && is_digit) begin
                case (state_reg)
                    EMPTY: begin
                        tens_reg  <= 4'd0;
                        unit_reg  <= kp.key_code;
                        state_reg <= ONE;
                        error_reg <= 1'b0;
                    end
                    ONE: begin
                        tens_reg  <= unit_reg;
                        unit_reg  <= kp.key_code;
                        state_reg <= TWO;
                        error_reg <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (press && (kp.key_code == KEY_CLEAR)) begin
                tens_reg  <= 4'd0;
                unit_reg  <= 4'd0;
                state_reg <= EMPTY;
                error_reg <= 1'b0;
            end
        end
    end

    assign kp.value_out   = value_reg;
    assign kp.value_valid = valid_reg;
    assign kp.entry_tens  = tens_reg;
    assign kp.entry_unit  = unit_reg;
    assign kp.digit_count = 2'(state_reg);
    assign kp.error       = error_reg;
endmodule

// File: tb/tb_keypad_concatener.sv
// Directed + randomized keypad sequences checked against a digit-queue model of the entry.
module tb_keypad_concatener;
    localparam int WIDTH     = 4;
    localparam int MAX_VALUE = 15;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    keypad_concatener_if #(.WIDTH(WIDTH)) kp ();

    keypad_concatener #(.WIDTH(WIDTH), .MAX_VALUE(MAX_VALUE)) dut (
        .clock (clk),
        .reset (reset),
        .kp    (kp.slave)
    );

    always #5 clk = ~clk;

    // Model: the digits typed so far, in typing order, plus commit results.
    int m_digits[$];
    int m_value;
    bit m_valid;
    bit m_error;

    task automatic model_reset();
        m_digits.delete();
        m_value = 0;
        m_valid = 1'b0;
        m_error = 1'b0;
    endtask

    task automatic model_commit();
        int v = 0;
        foreach (m_digits[i]) v = v * 10 + m_digits[i];
        m_digits.delete();
        if (v <= MAX_VALUE) begin
            m_value = v;
            m_valid = 1'b1;
            m_error = 1'b0;
        end else begin
            m_error = 1'b1;
        end
    endtask

    task automatic model_event(input int code);
        m_valid = 1'b0;
        if (code <= 9) begin
            if (m_digits.size() < 2) begin
                m_digits.push_back(code);
                m_error = 1'b0;
`ifdef KEYPAD_CONCATENER_AUTOCOMMIT_EN
                if (m_digits.size() == 2) model_commit();
`endif
            end
        end else if (code == 10) begin
            m_digits.delete();
            m_error = 1'b0;
        end else if (code == 11) begin
            if (m_digits.size() > 0) model_commit();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int tens = (m_digits.size() == 2) ? m_digits[0] : 0;
        int unit = (m_digits.size() == 0) ? 0 : m_digits[m_digits.size() - 1];
        check({tag, ".value"}, 32'(kp.value_out),   32'(m_value));
        check({tag, ".valid"}, 32'(kp.value_valid), 32'(m_valid));
        check({tag, ".tens"},  32'(kp.entry_tens),  32'(tens));
        check({tag, ".unit"},  32'(kp.entry_unit),  32'(unit));
        check({tag, ".count"}, 32'(kp.digit_count), 32'(m_digits.size()));
        check({tag, ".error"}, 32'(kp.error),       32'(m_error));
    endtask

    // One key press: event edge, remaining held cycles, then release gap.
    task automatic press(input int code, input int hold, input int gap, input bit scramble);
        kp.key_code    = 4'(code);
        kp.key_pressed = 1'b1;
        @(posedge clk); #1;
        model_event(code);
        check_all($sformatf("press%0d", code));
        m_valid = 1'b0;
        for (int i = 1; i < hold; i++) begin
            if (scramble) kp.key_code = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            check_all("held");
        end
        kp.key_pressed = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            check_all("gap");
        end
    endtask

    initial begin
        kp.key_code    = 4'd0;
        kp.key_pressed = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // 1, 2, Enter -> 12
        press(1, 3, 2, 0);
        press(2, 3, 2, 0);
        press(11, 1, 0, 0);
        check("commit12.value", 32'(kp.value_out), 32'd12);
        check("commit12.pulse", 32'(kp.value_valid), 32'd1);
        kp.key_pressed = 1'b0;
        @(posedge clk); #1;
        check("commit12.pulse_end", 32'(kp.value_valid), 32'd0);
        press(0, 1, 1, 0);   // digit then clear so the model stays aligned
        press(10, 2, 2, 0);

        // 2, 0, Enter -> 20 out of range
        press(2, 3, 2, 0);
        press(0, 3, 2, 0);
        press(11, 3, 2, 0);
        check("range.error", 32'(kp.error), 32'd1);
        check("range.value", 32'(kp.value_out), 32'd12);
        press(7, 3, 2, 0);
        check("clear_err.unit", 32'(kp.entry_unit), 32'd7);

        // Long hold of 5 yields one digit; 0xE ignored
        press(10, 2, 2, 0);
        press(5, 10, 2, 0);
        press(14, 3, 2, 0);

        // 1, 2, 3, Enter; 9, Clear, Enter
        press(1, 3, 2, 0);
        press(2, 3, 2, 0);
        press(3, 3, 2, 0);
        press(11, 3, 2, 0);
        press(9, 3, 2, 0);
        press(10, 3, 2, 0);
        press(11, 3, 2, 0);

        // Reset while key 4 is held, then key stays held
        press(1, 2, 2, 0);
        kp.key_code    = 4'd4;
        kp.key_pressed = 1'b1;
        @(posedge clk); #1;
        model_event(4);
        check_all("pre_reset");
        m_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
        check_all("mid_reset");
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check_all("held_after_reset");
        end
        kp.key_pressed = 1'b0;
        @(posedge clk); #1;
        press(4, 2, 2, 0);

`ifdef KEYPAD_CONCATENER_AUTOCOMMIT_EN
        press(10, 1, 1, 0);
        press(1, 2, 2, 0);
        press(4, 1, 0, 0);
        check("auto14.value", 32'(kp.value_out), 32'd14);
        kp.key_pressed = 1'b0;
        @(posedge clk); #1;
        press(3, 2, 2, 0);
        press(3, 2, 2, 0);
        check("auto33.error", 32'(kp.error), 32'd1);
`endif

        // Randomized presses, key code scrambled while held
        for (int n = 0; n < 200; n++) begin
            int code;
            code = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15))
                                               : int'($urandom_range(0, 9));
            press(code, $urandom_range(1, 4), $urandom_range(1, 3), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/keypad_concatener.md
Name: keypad_concatener

Overview:
- Inverse of the tens/unit digit splitter: assembles a binary value from decimal digits typed on the keypad.
- Takes keypad scanner output (level key-held flag plus 4-bit key code) and edge-detects presses.
- Shifts up to two decimal digits into a tens/unit entry register, then commits tens*10+unit as a binary value on Enter.
- Sits between the keypad scanner and the address/data registers that feed the memory under test. Exposes the live tens/unit entry for the 7-segment display.

Parameters:
- WIDTH, 4, width of committed binary value ValueOut.
- MAX_VALUE, 15, largest committable value (must be <= 2^WIDTH-1 and <= 99).

Ports:
- Clock  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- KeyCode  input  4  code of key held: 0-9 digits, 0xA Clear, 0xB Enter, 0xC-0xF ignored.
- KeyPressed  input  1  level, high while a key is held (already debounced upstream).
- ValueOut  output  WIDTH  last committed binary value.
- ValueValid  output  1  one-cycle pulse when ValueOut is updated.
- EntryTens  output  4  BCD tens digit of entry in progress.
- EntryUnit  output  4  BCD unit digit of entry in progress.
- DigitCount  output  2  digits currently held (0, 1 or 2).
- Error  output  1  sticky out-of-range flag.

Behaviour:
- Reset values: ValueOut=0, ValueValid=0, EntryTens=0, EntryUnit=0, DigitCount=0, Error=0, state EMPTY. KeyPrev resets to 1, so a key held through reset release is not registered.
- Press event: KeyPressed=1 and KeyPrev=0 in the same cycle. KeyPrev<=KeyPressed every cycle. A held key yields exactly one event.
- Latency: all outputs reflect an event on the clock edge that samples it (one cycle).
- FSM states EMPTY (DigitCount=0), ONE (1), TWO (2):
  - Digit d in EMPTY: EntryUnit<=d, EntryTens<=0, go ONE, Error<=0.
  - Digit d in ONE: EntryTens<=EntryUnit, EntryUnit<=d, go TWO, Error<=0.
  - Digit in TWO: ignored. No state change, no error.
  - Clear in any state: EntryTens/EntryUnit<=0, go EMPTY, Error<=0.
  - Enter in EMPTY: ignored.
  - Enter in ONE/TWO: compute V=EntryTens*10+EntryUnit at 7 bits (max 99). Entry is then cleared and state goes EMPTY.
    - V<=MAX_VALUE: ValueOut<=V[WIDTH-1:0], ValueValid<=1 for exactly one cycle, Error<=0.
    - V>MAX_VALUE: Error<=1, ValueOut unchanged, no ValueValid pulse.
  - Codes 0xC-0xF: ignored in all states.
- ValueValid is 0 in every cycle not directly following a successful commit. Back-to-back commits need separate presses, so pulses are never merged.
- Error holds until the next accepted digit, Clear, successful commit, or Reset.
- Reset asserted mid-entry: all state returns to reset values on that edge. No commit occurs.
- KeyCode is sampled only in the event cycle. Changes while held are ignored.

Optional Feature:
- Macro KEYPAD_CONCATENER_AUTOCOMMIT_EN.
- Defined: when a digit moves the FSM ONE->TWO, the commit (range check, ValueValid or Error, clear to EMPTY) happens on that same edge, without Enter. Enter still commits from ONE. TWO is never held, so DigitCount never reads 2 externally.
- Undefined: behaviour exactly as above; Enter is required to commit.

Test Plan:
- Reset, press 1, 2, Enter (each held 3 cycles, 2-cycle gaps), MAX_VALUE=15 -> after Enter edge ValueOut=12, ValueValid high exactly 1 cycle, DigitCount=0, Error=0.
- Press 2, 0, Enter -> Error=1, no ValueValid, ValueOut stays 12. Then press 7 -> Error=0, EntryUnit=7, DigitCount=1.
- Hold KeyCode=5 for 10 cycles -> exactly one digit registered: EntryUnit=5, EntryTens=0, DigitCount=1. Press 0xE -> no change.
- Press 1, 2, 3, Enter -> third digit ignored, ValueOut=12. Press 9, Clear, Enter -> entry cleared, Enter ignored, no ValueValid.
- Assert Reset for 1 cycle with DigitCount=2 while key 4 held, then keep key 4 held -> all outputs 0, no digit registered until key released and re-pressed.
- With KEYPAD_CONCATENER_AUTOCOMMIT_EN: press 1, 4 -> ValueOut=14, ValueValid pulse on second digit's edge, DigitCount=0. Press 3, 3 -> Error=1, ValueOut stays 14.
